// File: rtl/regfile_wb_arbiter_pkg.sv
// Register-file constants shared by the writeback path, plus the ring-index helper
// used to advance the round-robin pointer.
package regfile_wb_arbiter_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NR_REGS    = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  function automatic int ring_next(input int idx, input int n);
    return ((idx + 1) >= n) ? 0 : (idx + 1);
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_wb_rr_select.sv
// Circular scan from the round-robin pointer that grants up to NR_WRITE_PORTS
// valid requesters, skipping any whose address is already granted this cycle.
module wb_rr_select
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int NR_REQ         = 4,
  parameter int NR_WRITE_PORTS = 2,
  parameter int PTR_W          = (NR_REQ > 1) ? $clog2(NR_REQ) : 1
) (
  input  logic                                 i_en,
  input  logic [NR_REQ-1:0]                    i_valid,
  input  reg_addr_t [NR_REQ-1:0]               i_addr,
  input  logic [PTR_W-1:0]                     i_rr_ptr,
  output logic [NR_REQ-1:0]                    o_grant,
  output logic [NR_WRITE_PORTS-1:0]            o_port_vld,
  output logic [NR_WRITE_PORTS-1:0][PTR_W-1:0] o_port_idx,
  output logic                                 o_any,
  output logic [PTR_W-1:0]                     o_last
);

  logic [PTR_W-1:0] w_sel;
  logic             w_hit;
  logic             w_take;
  int               w_cnt;

  // Walk the ring once; the k-th accepted requester is steered to write port k.
  always_comb begin
    o_grant    = '0;
    o_port_vld = '0;
    o_port_idx = '0;
    o_any      = 1'b0;
    o_last     = i_rr_ptr;
    w_sel      = '0;
    w_hit      = 1'b0;
    w_take     = 1'b0;
    w_cnt      = 0;
    for (int o = 0; o < NR_REQ; o++) begin
      w_sel = PTR_W'((int'(i_rr_ptr) + o) % NR_REQ);
      w_hit = 1'b0;
      for (int j = 0; j < NR_REQ; j++) begin
        w_hit = w_hit | (o_grant[j] & (i_addr[j] == i_addr[w_sel]));
      end
      w_take = i_en & i_valid[w_sel] & (w_cnt < NR_WRITE_PORTS) & ~w_hit;
      o_grant[w_sel] = o_grant[w_sel] | w_take;
      for (int k = 0; k < NR_WRITE_PORTS; k++) begin
        o_port_vld[k] = o_port_vld[k] | (w_take & (k == w_cnt));
        o_port_idx[k] = (w_take && (k == w_cnt)) ? w_sel : o_port_idx[k];
      end
      o_last = w_take ? w_sel : o_last;
      o_any  = o_any | w_take;
      w_cnt  = w_cnt + int'(w_take);
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: picks functional-unit results for the register-file write
// ports and keeps the pending-write scoreboard for issued destinations.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH     = 64,
  parameter int NR_REQ         = 4,
  parameter int NR_WRITE_PORTS = 2
) (
  input  logic                                         clk_i,
  input  logic                                         rst_ni,
  input  logic                                         flush_i,
  input  logic [NR_REQ-1:0]                            req_valid_i,
  output logic [NR_REQ-1:0]                            req_ready_o,
  input  logic [NR_REQ-1:0][REG_ADDR_W-1:0]            req_addr_i,
  input  logic [NR_REQ-1:0][DATA_WIDTH-1:0]            req_data_i,
  input  logic                                         issue_valid_i,
  input  logic [REG_ADDR_W-1:0]                        issue_rd_i,
  output logic [NR_REGS-1:0]                           busy_o,
  output logic [NR_WRITE_PORTS-1:0]                    we_o,
  output logic [NR_WRITE_PORTS-1:0][REG_ADDR_W-1:0]    waddr_o,
  output logic [NR_WRITE_PORTS-1:0][DATA_WIDTH-1:0]    wdata_o
);

  localparam int PTR_W = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;

  logic [PTR_W-1:0]                            r_rr_ptr;
  logic [NR_REGS-1:0]                          r_busy;
  logic [NR_WRITE_PORTS-1:0]                   r_we;
  logic [NR_WRITE_PORTS-1:0][REG_ADDR_W-1:0]   r_waddr;
  logic [NR_WRITE_PORTS-1:0][DATA_WIDTH-1:0]   r_wdata;

  logic [NR_REQ-1:0]                           w_grant;
  logic [NR_WRITE_PORTS-1:0]                   w_port_vld;
  logic [NR_WRITE_PORTS-1:0][PTR_W-1:0]        w_port_idx;
  logic                                        w_any;
  logic [PTR_W-1:0]                            w_last;
  logic [NR_REGS-1:0]                          w_clr;
  logic [NR_REGS-1:0]                          w_set;
  logic [NR_REGS-1:0]                          w_busy_nxt;

  // Holding the scan disabled in reset keeps every ready low.
  wb_rr_select #(
    .NR_REQ         (NR_REQ),
    .NR_WRITE_PORTS (NR_WRITE_PORTS),
    .PTR_W          (PTR_W)
  ) u_select (
    .i_en       (rst_ni),
    .i_valid    (req_valid_i),
    .i_addr     (req_addr_i),
    .i_rr_ptr   (r_rr_ptr),
    .o_grant    (w_grant),
    .o_port_vld (w_port_vld),
    .o_port_idx (w_port_idx),
    .o_any      (w_any),
    .o_last     (w_last)
  );

  assign req_ready_o = w_grant;

  // Issue set beats a same-cycle writeback clear; flush beats both.
  always_comb begin
    w_clr = '0;
    w_set = '0;
    for (int i = 0; i < NR_REQ; i++) begin
      w_clr[req_addr_i[i]] = w_clr[req_addr_i[i]] | w_grant[i];
    end
    w_set[issue_rd_i] = issue_valid_i;
    w_busy_nxt        = flush_i ? '0 : ((r_busy & ~w_clr) | w_set);
    w_busy_nxt[0]     = 1'b0;
  end

  // Scoreboard, ring pointer and registered write-port outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_rr_ptr <= '0;
      r_busy   <= '0;
      r_we     <= '0;
      r_waddr  <= '0;
      r_wdata  <= '0;
    end else begin
      r_busy   <= w_busy_nxt;
      r_rr_ptr <= w_any ? PTR_W'(ring_next(int'(w_last), NR_REQ)) : r_rr_ptr;
      for (int k = 0; k < NR_WRITE_PORTS; k++) begin
        r_we[k]    <= w_port_vld[k] & (req_addr_i[w_port_idx[k]] != '0);
        r_waddr[k] <= w_port_vld[k] ? req_addr_i[w_port_idx[k]] : '0;
        r_wdata[k] <= w_port_vld[k] ? req_data_i[w_port_idx[k]] : '0;
      end
    end
  end

  assign busy_o  = r_busy;
  assign we_o    = r_we;
  assign waddr_o = r_waddr;
  assign wdata_o = r_wdata;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed scenarios plus randomized traffic, checked against a queue-based
// reference of the scan-order grant rules and the scoreboard.
module tb_regfile_wb_arbiter;
  localparam int NR = 4;
  localparam int NP = 2;
  localparam int DW = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst_n, flush, issue_v;
  logic [4:0]             issue_rd;
  logic [NR-1:0]          valid;
  logic [NR-1:0][4:0]     addr;
  logic [NR-1:0][DW-1:0]  data;
  logic [NR-1:0]          ready;
  logic [31:0]            busy;
  logic [NP-1:0]          we;
  logic [NP-1:0][4:0]     waddr;
  logic [NP-1:0][DW-1:0]  wdata;

  regfile_wb_arbiter #(.DATA_WIDTH(DW), .NR_REQ(NR), .NR_WRITE_PORTS(NP)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .req_valid_i(valid), .req_ready_o(ready), .req_addr_i(addr), .req_data_i(data),
    .issue_valid_i(issue_v), .issue_rd_i(issue_rd), .busy_o(busy),
    .we_o(we), .waddr_o(waddr), .wdata_o(wdata)
  );

  int n_vec = 0;
  int n_fail = 0;

  int                     m_ptr;
  logic [31:0]            m_busy;
  logic [NP-1:0]          m_we;
  logic [NP-1:0][4:0]     m_waddr;
  logic [NP-1:0][DW-1:0]  m_wdata;
  logic [NR-1:0]          e_ready;
  int                     p_ptr;
  logic [31:0]            p_busy;
  logic [NP-1:0]          p_we;
  logic [NP-1:0][4:0]     p_waddr;
  logic [NP-1:0][DW-1:0]  p_wdata;

  // Reference: walk requesters from the pointer, take distinct addresses until ports run out.
  task automatic predict();
    int granted[$];
    logic [4:0] used[$];
    bit dup;
    int slot;
    #2;
    e_ready = '0; p_we = '0; p_waddr = '0; p_wdata = '0;
    p_busy = '0; p_ptr = 0;
    if (rst_n) begin
      for (int o = 0; o < NR; o++) begin
        int i;
        i = (m_ptr + o) % NR;
        dup = 1'b0;
        foreach (used[u]) if (used[u] == addr[i]) dup = 1'b1;
        if (valid[i] && granted.size() < NP && !dup) begin
          slot = granted.size();
          p_we[slot] = (addr[i] != 5'd0);
          p_waddr[slot] = addr[i];
          p_wdata[slot] = data[i];
          granted.push_back(i);
          used.push_back(addr[i]);
          e_ready[i] = 1'b1;
        end
      end
      p_busy = m_busy;
      foreach (used[u]) p_busy[used[u]] = 1'b0;
      if (issue_v && issue_rd != 5'd0) p_busy[issue_rd] = 1'b1;
      if (flush) p_busy = '0;
      p_ptr = (granted.size() > 0) ? (granted[granted.size()-1] + 1) % NR : m_ptr;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    m_ptr = p_ptr; m_busy = p_busy; m_we = p_we; m_waddr = p_waddr; m_wdata = p_wdata;
  endtask

  task automatic idle();
    valid = '0; flush = 1'b0; issue_v = 1'b0; issue_rd = 5'd0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; idle();
    valid = 4'hF; addr = {5'd4, 5'd3, 5'd2, 5'd1}; data = '1;
    m_ptr = 0; m_busy = '0;
    for (int c = 0; c < 2; c++) begin
      predict();
      n_vec++; if (ready !== 4'b0000 || ready !== e_ready) begin n_fail++; $display("FAIL reset_ready: got %b want 0000", ready); end
      tick();
    end
    n_vec++; if (we !== 2'b00) begin n_fail++; $display("FAIL reset_we: got %b want 00", we); end
    n_vec++; if (busy !== 32'd0) begin n_fail++; $display("FAIL reset_busy: got %h want 0", busy); end
    n_vec++; if (waddr !== '0 || wdata !== '0) begin n_fail++; $display("FAIL reset_wport: got %h/%h want 0", waddr, wdata); end
  endtask

  task automatic test_rr_basic();
    rst_n = 1'b1; idle();
    valid = 4'hF; addr = {5'd8, 5'd7, 5'd6, 5'd5};
    for (int i = 0; i < NR; i++) data[i] = {$urandom(), $urandom()};
    predict();
    n_vec++; if (ready !== 4'b0011 || ready !== e_ready) begin n_fail++; $display("FAIL rr_ready1: got %b want 0011", ready); end
    tick();
    n_vec++; if (we !== 2'b11 || waddr[0] !== 5'd5 || waddr[1] !== 5'd6) begin n_fail++; $display("FAIL rr_write1: got we=%b a=%0d,%0d want 11 5,6", we, waddr[0], waddr[1]); end
    n_vec++; if (wdata !== {data[1], data[0]}) begin n_fail++; $display("FAIL rr_data1: got %h want %h", wdata, {data[1], data[0]}); end
    valid = 4'b1100;
    predict();
    n_vec++; if (ready !== 4'b1100 || ready !== e_ready) begin n_fail++; $display("FAIL rr_ready2: got %b want 1100", ready); end
    tick();
    n_vec++; if (we !== 2'b11 || waddr[0] !== 5'd7 || waddr[1] !== 5'd8) begin n_fail++; $display("FAIL rr_write2: got we=%b a=%0d,%0d want 11 7,8", we, waddr[0], waddr[1]); end
    idle(); predict(); tick();
    n_vec++; if (we !== 2'b00) begin n_fail++; $display("FAIL rr_idle: got %b want 00", we); end
  endtask

  task automatic test_conflict();
    idle();
    valid = 4'b0110; addr[1] = 5'd9; addr[2] = 5'd9;
    data[1] = 64'h1111; data[2] = 64'h2222;
    predict();
    n_vec++; if (ready !== 4'b0010 || ready !== e_ready) begin n_fail++; $display("FAIL conf_ready1: got %b want 0010", ready); end
    tick();
    n_vec++; if (we !== 2'b01 || waddr[0] !== 5'd9 || wdata[0] !== 64'h1111) begin n_fail++; $display("FAIL conf_write1: got we=%b a=%0d d=%h", we, waddr[0], wdata[0]); end
    valid = 4'b0100;
    predict();
    n_vec++; if (ready !== 4'b0100 || ready !== e_ready) begin n_fail++; $display("FAIL conf_ready2: got %b want 0100", ready); end
    tick();
    n_vec++; if (we !== 2'b01 || waddr[0] !== 5'd9 || wdata[0] !== 64'h2222) begin n_fail++; $display("FAIL conf_write2: got we=%b a=%0d d=%h", we, waddr[0], wdata[0]); end
  endtask

  task automatic test_reg0();
    idle();
    valid = 4'b1000; addr[3] = 5'd0; data[3] = 64'hFF;
    predict();
    n_vec++; if (ready !== 4'b1000 || ready !== e_ready) begin n_fail++; $display("FAIL reg0_ready: got %b want 1000", ready); end
    tick();
    n_vec++; if (we !== 2'b00) begin n_fail++; $display("FAIL reg0_we: got %b want 00", we); end
  endtask

  task automatic test_busy_race();
    idle(); issue_v = 1'b1; issue_rd = 5'd4;
    predict(); tick();
    n_vec++; if (busy[4] !== 1'b1) begin n_fail++; $display("FAIL race_set: got %b want 1", busy[4]); end
    valid = 4'b0001; addr[0] = 5'd4;
    predict();
    n_vec++; if (ready !== 4'b0001 || ready !== e_ready) begin n_fail++; $display("FAIL race_ready: got %b want 0001", ready); end
    tick();
    n_vec++; if (busy[4] !== 1'b1 || busy !== m_busy) begin n_fail++; $display("FAIL race_keep: got %h want bit4 set", busy); end
    issue_v = 1'b0;
    predict(); tick();
    n_vec++; if (busy[4] !== 1'b0 || busy !== m_busy) begin n_fail++; $display("FAIL race_clear: got %h want %h", busy, m_busy); end
  endtask

  task automatic test_flush();
    idle();
    for (int r = 4; r < 8; r++) begin
      issue_v = 1'b1; issue_rd = 5'(r);
      predict(); tick();
    end
    n_vec++; if (busy !== 32'h0000_00F0) begin n_fail++; $display("FAIL flush_pre: got %h want 000000f0", busy); end
    flush = 1'b1; issue_rd = 5'd12;
    predict(); tick();
    n_vec++; if (busy !== 32'd0) begin n_fail++; $display("FAIL flush_clear: got %h want 0", busy); end
    issue_v = 1'b0; valid = 4'b0010; addr[1] = 5'd3; data[1] = 64'hABCD;
    predict(); tick();
    n_vec++; if (we !== 2'b01 || waddr[0] !== 5'd3 || wdata[0] !== 64'hABCD) begin n_fail++; $display("FAIL flush_write: got we=%b a=%0d d=%h", we, waddr[0], wdata[0]); end
  endtask

  task automatic test_reset_mid();
    idle(); issue_v = 1'b1; issue_rd = 5'd10;
    predict(); tick();
    issue_v = 1'b0; valid = 4'b0001; addr[0] = 5'd11; rst_n = 1'b0;
    predict();
    n_vec++; if (ready !== 4'b0000) begin n_fail++; $display("FAIL rstmid_ready: got %b want 0000", ready); end
    tick();
    n_vec++; if (we !== 2'b00 || busy !== 32'd0) begin n_fail++; $display("FAIL rstmid_out: got we=%b busy=%h want 0", we, busy); end
    rst_n = 1'b1; valid = 4'hF; addr = {5'd4, 5'd3, 5'd2, 5'd1};
    predict();
    n_vec++; if (ready !== 4'b0011 || ready !== e_ready) begin n_fail++; $display("FAIL rstmid_ptr: got %b want 0011", ready); end
    tick();
    idle(); predict(); tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst_n = ($urandom_range(0, 63) != 0);
      flush = ($urandom_range(0, 15) == 0);
      valid = NR'($urandom());
      for (int i = 0; i < NR; i++) begin
        addr[i] = 5'($urandom_range(0, 7));
        data[i] = {$urandom(), $urandom()};
      end
      issue_v = 1'($urandom_range(0, 1));
      issue_rd = 5'($urandom_range(0, 7));
      predict();
      n_vec++; if (ready !== e_ready) begin n_fail++; $display("FAIL rnd_ready c=%0d: got %b want %b", c, ready, e_ready); end
      tick();
      n_vec++; if (we !== m_we) begin n_fail++; $display("FAIL rnd_we c=%0d: got %b want %b", c, we, m_we); end
      n_vec++; if (busy !== m_busy) begin n_fail++; $display("FAIL rnd_busy c=%0d: got %h want %h", c, busy, m_busy); end
      for (int k = 0; k < NP; k++) begin
        if (m_we[k]) begin
          n_vec++;
          if (waddr[k] !== m_waddr[k] || wdata[k] !== m_wdata[k]) begin
            n_fail++; $display("FAIL rnd_port%0d c=%0d: got %0d/%h want %0d/%h", k, c, waddr[k], wdata[k], m_waddr[k], m_wdata[k]);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_rr_basic();
    test_conflict();
    test_reg0();
    test_busy_race();
    test_flush();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
